// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor.
//   state_t   : controller states (IDLE, RUN, DONE)
//   MODE_ADD  : mode encoding for A + B
//   MODE_SUB  : mode encoding for A - B (A + ~B + 1)
//   cnt_width : digit counter width, never narrower than one bit
package add_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_add_sub_if.sv
// Start/done handshake and operand/result bus of the serial adder/subtractor.
//   start, mode, a, b                        : request side (master drives)
//   ready, done, result, carry_out,
//   overflow, zero                           : response side (slave drives)
interface serial_add_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             overflow;
    logic             zero;

    modport master (
        output start, mode, a, b,
        input  ready, done, result, carry_out, overflow, zero
    );

    modport slave (
        input  start, mode, a, b,
        output ready, done, result, carry_out, overflow, zero
    );
endinterface

// File: rtl/serial_add_sub_digit_full_adder.sv
// digit_full_adder: DIGIT one-bit full adders chained ripple-style.
//   a, b   : operand digits
//   cin    : carry into bit 0
//   sum    : sum digit
//   cout   : carry out of the top bit
//   c_top  : carry into the top bit (used for signed overflow detection)
module digit_full_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_top
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fa
            assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout  = c[DIGIT];
    assign c_top = c[DIGIT-1];
endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: multi-cycle two's-complement adder/subtractor that consumes
// DIGIT operand bits per clock through a chained full-adder digit slice.
//   clk    : rising-edge clock
//   rst_n  : synchronous, active-low reset
//   bus    : slave side of serial_add_sub_if (start/mode/a/b in,
//            ready/done/result/carry_out/overflow/zero out)
// Optional build macro SERIAL_ADD_SUB_SAT_EN: clamp overflowing results to the
// signed limit (zero is computed on the clamped value).
module serial_add_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_sub_if.slave   bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]   a_sh_reg;
    logic [WIDTH-1:0]   b_sh_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic               carry_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               carry_out_reg;
    logic               overflow_reg;
    logic               zero_reg;

    logic [DIGIT-1:0]       sum_digit;
    logic                   slice_cout;
    logic                   slice_ctop;
    logic [WIDTH+DIGIT-1:0] acc_cat;
    logic [WIDTH-1:0]       acc_next;
    logic [WIDTH-1:0]       final_value;
    logic                   ovf_now;
    logic                   last_digit;

    digit_full_adder #(.DIGIT(DIGIT)) u_slice (
        .a     (a_sh_reg[DIGIT-1:0]),
        .b     (b_sh_reg[DIGIT-1:0]),
        .cin   (carry_reg),
        .sum   (sum_digit),
        .cout  (slice_cout),
        .c_top (slice_ctop)
    );

    // Sum digits enter at the MSB side; after N shifts the first digit has
    // reached bit 0. The concatenation keeps this legal when DIGIT == WIDTH.
    always_comb begin
        acc_cat    = {sum_digit, acc_reg};
        acc_next   = acc_cat[WIDTH+DIGIT-1:DIGIT];
        ovf_now    = slice_ctop ^ slice_cout;
        last_digit = (cnt_reg == CNT_W'(N - 1));
`ifdef SERIAL_ADD_SUB_SAT_EN
        // On overflow the wrapped sign is the opposite of the true sign:
        // wrapped negative means positive overflow -> 0111..1, and vice versa.
        final_value = ovf_now ? {~acc_next[WIDTH-1], {(WIDTH-1){acc_next[WIDTH-1]}}}
                              : acc_next;
`else
        final_value = acc_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            a_sh_reg      <= '0;
            b_sh_reg      <= '0;
            acc_reg       <= '0;
            carry_reg     <= 1'b0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_sh_reg  <= bus.a;
                        b_sh_reg  <= (bus.mode == MODE_SUB) ? ~bus.b : bus.b;
                        // Carry-in of 1 supplies the +1 of two's-complement negation.
                        carry_reg <= bus.mode;
                        cnt_reg   <= '0;
                        acc_reg   <= '0;
                    end
                end
                RUN: begin
                    a_sh_reg  <= a_sh_reg >> DIGIT;
                    b_sh_reg  <= b_sh_reg >> DIGIT;
                    carry_reg <= slice_cout;
                    acc_reg   <= acc_next;
                    cnt_reg   <= cnt_reg + CNT_W'(1);
                    if (last_digit) begin
                        result_reg    <= final_value;
                        carry_out_reg <= slice_cout;
                        overflow_reg  <= ovf_now;
                        zero_reg      <= (final_value == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready     = (state_reg == IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;
    assign bus.zero      = zero_reg;
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed testbench for serial_add_sub: a DIGIT=1 and a DIGIT=4 instance,
// both WIDTH=8, sharing clock and reset.
module tb_serial_add_sub;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    serial_add_sub_if #(.WIDTH(8)) bus8 ();
    serial_add_sub_if #(.WIDTH(8)) bus4 ();

    serial_add_sub #(.WIDTH(8), .DIGIT(1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    serial_add_sub #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

`ifdef SERIAL_ADD_SUB_SAT_EN
    localparam logic [7:0] EXP_80_M_01 = 8'h80;
    localparam logic [7:0] EXP_7F_P_01 = 8'h7F;
`else
    localparam logic [7:0] EXP_80_M_01 = 8'h7F;
    localparam logic [7:0] EXP_7F_P_01 = 8'h80;
`endif

    // Stimulus only: issue one request on the DIGIT=1 instance and return the
    // number of edges from accept to done (-1 if done never arrives).
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic mode,
                        output int lat);
        @(negedge clk);
        bus8.a = a; bus8.b = b; bus8.mode = mode; bus8.start = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs after the accepting edge; they must be ignored.
        bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.mode = ~mode;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin lat = i; break; end
        end
        $display("op %s a=%02h b=%02h lat=%0d result=%02h c=%0b v=%0b z=%0b",
                 mode ? "sub" : "add", a, b, lat, bus8.result, bus8.carry_out,
                 bus8.overflow, bus8.zero);
    endtask

    task automatic test_reset();
        bus8.start = 0; bus8.mode = 0; bus8.a = 0; bus8.b = 0;
        bus4.start = 0; bus4.mode = 0; bus4.a = 0; bus4.b = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus8.ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus8.ready); end
        total++; if (bus8.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus8.done); end
        total++; if (bus8.result !== 8'h00) begin bad++; $display("FAIL reset_result got=%02h want=00", bus8.result); end
        total++; if ({bus8.carry_out, bus8.overflow, bus8.zero} !== 3'b000) begin bad++;
            $display("FAIL reset_flags got=%03b want=000", {bus8.carry_out, bus8.overflow, bus8.zero}); end
        total++; if (bus4.ready !== 1'b1 || bus4.done !== 1'b0) begin bad++;
            $display("FAIL reset4_rdy_done got=%b%b want=10", bus4.ready, bus4.done); end
        total++; if (bus4.result !== 8'h00) begin bad++; $display("FAIL reset4_result got=%02h want=00", bus4.result); end
        $display("reset done ready=%b done=%b result=%02h", bus8.ready, bus8.done, bus8.result);
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add();
        int lat;
        run8(8'h3C, 8'h05, 1'b0, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL add_latency got=%0d want=8", lat); end
        total++; if (bus8.result !== 8'h41) begin bad++; $display("FAIL add_result got=%02h want=41", bus8.result); end
        total++; if ({bus8.carry_out, bus8.overflow, bus8.zero} !== 3'b000) begin bad++;
            $display("FAIL add_flags got=%03b want=000", {bus8.carry_out, bus8.overflow, bus8.zero}); end
        total++; if (bus8.ready !== 1'b0) begin bad++; $display("FAIL add_ready_in_done got=%b want=0", bus8.ready); end
        @(posedge clk); #1;
        total++; if (bus8.done !== 1'b0 || bus8.ready !== 1'b1) begin bad++;
            $display("FAIL add_done_pulse got=done%b ready%b want=done0 ready1", bus8.done, bus8.ready); end
        total++; if (bus8.result !== 8'h41) begin bad++; $display("FAIL add_result_hold got=%02h want=41", bus8.result); end
    endtask

    task automatic test_sub();
        int lat;
        run8(8'h05, 8'h07, 1'b1, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL sub1_latency got=%0d want=8", lat); end
        total++; if (bus8.result !== 8'hFE) begin bad++; $display("FAIL sub1_result got=%02h want=FE", bus8.result); end
        total++; if ({bus8.carry_out, bus8.overflow, bus8.zero} !== 3'b000) begin bad++;
            $display("FAIL sub1_flags got=%03b want=000", {bus8.carry_out, bus8.overflow, bus8.zero}); end
        @(posedge clk);
        run8(8'h5A, 8'h5A, 1'b1, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL sub2_latency got=%0d want=8", lat); end
        total++; if (bus8.result !== 8'h00) begin bad++; $display("FAIL sub2_result got=%02h want=00", bus8.result); end
        total++; if ({bus8.carry_out, bus8.overflow, bus8.zero} !== 3'b101) begin bad++;
            $display("FAIL sub2_flags got=%03b want=101", {bus8.carry_out, bus8.overflow, bus8.zero}); end
        @(posedge clk);
    endtask

    task automatic test_overflow();
        int lat;
        run8(8'h80, 8'h01, 1'b1, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL ovf_sub_latency got=%0d want=8", lat); end
        total++; if (bus8.result !== EXP_80_M_01) begin bad++;
            $display("FAIL ovf_sub_result got=%02h want=%02h", bus8.result, EXP_80_M_01); end
        total++; if ({bus8.carry_out, bus8.overflow, bus8.zero} !== 3'b110) begin bad++;
            $display("FAIL ovf_sub_flags got=%03b want=110", {bus8.carry_out, bus8.overflow, bus8.zero}); end
        @(posedge clk);
        run8(8'h7F, 8'h01, 1'b0, lat);
        total++; if (lat !== 8) begin bad++; $display("FAIL ovf_add_latency got=%0d want=8", lat); end
        total++; if (bus8.result !== EXP_7F_P_01) begin bad++;
            $display("FAIL ovf_add_result got=%02h want=%02h", bus8.result, EXP_7F_P_01); end
        total++; if ({bus8.carry_out, bus8.overflow, bus8.zero} !== 3'b010) begin bad++;
            $display("FAIL ovf_add_flags got=%03b want=010", {bus8.carry_out, bus8.overflow, bus8.zero}); end
        @(posedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic seen_done;
        seen_done = 1'b0;
        @(negedge clk);
        bus8.a = 8'h3C; bus8.b = 8'h05; bus8.mode = 1'b0; bus8.start = 1'b1;
        @(posedge clk); #1;                       // E0: accepted
        total++; if (bus8.ready !== 1'b0) begin bad++; $display("FAIL midrst_busy_ready got=%b want=0", bus8.ready); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (bus8.done) seen_done = 1'b1;
        end
        rst_n = 1'b0;                             // low for RUN cycle 4
        @(posedge clk); #1;
        if (bus8.done) seen_done = 1'b1;
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL midrst_no_done got=%b want=0", seen_done); end
        total++; if (bus8.ready !== 1'b1 || bus8.done !== 1'b0) begin bad++;
            $display("FAIL midrst_rdy_done got=%b%b want=10", bus8.ready, bus8.done); end
        total++; if (bus8.result !== 8'h00) begin bad++; $display("FAIL midrst_result got=%02h want=00", bus8.result); end
        total++; if ({bus8.carry_out, bus8.overflow, bus8.zero} !== 3'b000) begin bad++;
            $display("FAIL midrst_flags got=%03b want=000", {bus8.carry_out, bus8.overflow, bus8.zero}); end
        $display("reset mid-run ready=%b result=%02h", bus8.ready, bus8.result);
        rst_n = 1'b1;
        // start is still high: the next edge must accept a fresh request.
        @(posedge clk); #1;
        total++; if (bus8.ready !== 1'b0) begin bad++; $display("FAIL midrst_reaccept got=ready%b want=ready0", bus8.ready); end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus8.done) begin lat = i; break; end
        end
        bus8.start = 1'b0;
        $display("op add a=3c b=05 after reset lat=%0d result=%02h", lat, bus8.result);
        total++; if (lat !== 8) begin bad++; $display("FAIL midrst_latency got=%0d want=8", lat); end
        total++; if (bus8.result !== 8'h41) begin bad++; $display("FAIL midrst_result2 got=%02h want=41", bus8.result); end
        @(posedge clk);
    endtask

    task automatic test_digit4();
        int lat;
        @(negedge clk);
        bus4.a = 8'hFF; bus4.b = 8'h01; bus4.mode = 1'b0; bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0; bus4.a = 8'h00; bus4.b = 8'h00;
        lat = -1;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (bus4.done) begin lat = i; break; end
        end
        $display("op add(d4) a=ff b=01 lat=%0d result=%02h c=%0b v=%0b z=%0b",
                 lat, bus4.result, bus4.carry_out, bus4.overflow, bus4.zero);
        total++; if (lat !== 2) begin bad++; $display("FAIL d4_latency got=%0d want=2", lat); end
        total++; if (bus4.result !== 8'h00) begin bad++; $display("FAIL d4_result got=%02h want=00", bus4.result); end
        total++; if ({bus4.carry_out, bus4.overflow, bus4.zero} !== 3'b101) begin bad++;
            $display("FAIL d4_flags got=%03b want=101", {bus4.carry_out, bus4.overflow, bus4.zero}); end
        @(posedge clk); #1;
        total++; if (bus4.done !== 1'b0 || bus4.ready !== 1'b1) begin bad++;
            $display("FAIL d4_done_pulse got=done%b ready%b want=done0 ready1", bus4.done, bus4.ready); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_reset_mid_run();
        test_digit4();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Parametrised multi-cycle two's-complement adder/subtractor that processes operands DIGIT bits per clock through a chained full-adder digit slice, computing A + B or A + ~B + 1. It is the sequential, width-generic successor to the fixed 4-bit ripple subtractor and sits in the lab datapath as the shared arithmetic unit behind a start/done handshake. Status flags (carry, signed overflow, zero) are produced alongside the result.

## Interface
- WIDTH, 8, operand/result width in bits; must be at least 2.
- DIGIT, 1, bits processed per cycle; WIDTH % DIGIT must be 0. N = WIDTH/DIGIT.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous and active-low (one clock; reset is synchronous and active-low).
- start  input  1  request; accepted only while ready=1.
- mode  input  1  0 = add (A+B), 1 = subtract (A-B); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ready  output  1  high in IDLE.
- done  output  1  one-cycle pulse; result and flags valid.
- result  output  WIDTH  sum/difference.
- carry_out  output  1  final carry; in subtract, 1 = no borrow (A >= B unsigned).
- overflow  output  1  signed overflow.
- zero  output  1  result == 0.

## Operation
- States: IDLE, RUN, DONE. Reset: IDLE, ready=1, done=0, result=0, carry_out=0, overflow=0, zero=0, digit counter=0.
- IDLE: on start=1, capture a, b (B inverted when mode=1), mode; carry register = mode (the +1 of subtract). Go to RUN, ready=0.
- RUN: each cycle the digit slice adds the lowest DIGIT bits of the A and B shift registers plus the carry register; the sum digit shifts into result from the MSB side, carry updates. Counter increments; after digit N-1 go to DONE.
- Overflow = carry into MSB XOR carry out of MSB, taken from the last digit.
- DONE: done=1 for exactly one cycle, then IDLE. result/flags hold until the next accepted start.
- start while RUN or DONE is ignored (not queued); a, b, mode changes ignored outside the accepting edge.
- rst_n low in any state: next edge returns to reset values; an in-flight operation is abandoned, no done.
- All arithmetic is modulo 2^WIDTH; no width extension of result.

## Timing
- Start accepted at edge E0. Digit k is processed at edge E(k+1). DONE is entered at edge EN; done is high in the cycle following EN.
- Latency start-to-done: N cycles (WIDTH=8: DIGIT=1 gives 8, DIGIT=4 gives 2).
- ready returns high one cycle after done; minimum start-to-start spacing N+2 cycles.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADD_SUB_SAT_EN defined: when overflow=1, result is clamped to the signed limit: positive overflow gives 0111…1, negative overflow gives 1000…0. zero is computed on the clamped value; overflow and carry_out are still reported.
- Undefined: result is the wrapped modulo value; no clamp logic is built.

## Structure
- Package add_sub_pkg: state enum (IDLE, RUN, DONE), MODE_ADD=1'b0 / MODE_SUB=1'b1 constants.
- Sub-module digit_full_adder (parameter DIGIT): DIGIT one-bit full adders chained ripple-style; outputs the sum digit, carry out, and carry into its top bit (for overflow).
- Top holds FSM, counter (clog2(N) bits, minimum 1), operand shift registers, result register, flag logic.

## Test plan
- Reset: hold rst_n=0 for 2 cycles -> ready=1, done=0, result=0, all flags 0.
- WIDTH=8, DIGIT=1, add 8'h3C+8'h05 -> done 8 cycles after accept, result=8'h41, carry_out=0, overflow=0, zero=0.
- Subtract 8'h05-8'h07 -> result=8'hFE, carry_out=0 (borrow), overflow=0; subtract 8'h5A-8'h5A -> result=8'h00, zero=1, carry_out=1.
- Subtract 8'h80-8'h01 -> overflow=1, result=8'h7F (wrap) or 8'h80 with SERIAL_ADD_SUB_SAT_EN; add 8'h7F+8'h01 -> overflow=1, result=8'h80, or 8'h7F with SAT.
- start held high throughout and rst_n pulsed low at RUN cycle 4 -> busy start ignored, no done; IDLE with reset outputs next cycle, then a new start is accepted.
- DIGIT=4 build, add 8'hFF+8'h01 -> done 2 cycles after accept, result=8'h00, carry_out=1, zero=1, overflow=0.
